// File: rtl/flash_write_loader_pkg.sv
// Shared types and constants for the flash write loader: FSM encoding,
// header framing and the header length check.
package flash_write_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_STREAM = 3'd4,
    ST_DONE   = 3'd5
  } fsm_state_e;

  localparam int HDR_BYTES    = 6;
  localparam int SECTOR_BYTES = 4096;

  // A job must carry at least one byte and fit in the payload buffer.
  function automatic logic hdr_num_ok(input logic [15:0] num, input logic [15:0] depth);
    return (num != 16'd0) && (num <= depth);
  endfunction

endpackage

// File: rtl/flash_byte_ram.sv
// Simple dual-port byte RAM: one write port, one synchronous read port whose
// output register holds its value until the next read enable.
module flash_byte_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          system_clk,
  input  logic          system_reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Write port: contents are not reset, so the array maps onto block RAM.
  always_ff @(posedge system_clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: the output register clears on reset and holds between reads.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/flash_write_loader.sv
// Host byte stream to flash write engine feeder: parses a 6-byte header,
// buffers the payload, then streams it out one byte per data_req.
module flash_write_loader
  import flash_write_loader_pkg::*;
#(
  parameter int BUF_DEPTH = SECTOR_BYTES,
  parameter int BUF_AW    = 12
) (
  input  logic        system_clk,
  input  logic        system_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        data_req,
  input  logic        write_finish,
  output logic        pi_flag,
  output logic [31:0] write_start_addr,
  output logic [15:0] write_num,
  output logic [7:0]  write_data,
  output logic        busy,
  output logic        err_len
);

  localparam logic [15:0] BUF_DEPTH_16 = 16'(BUF_DEPTH);
  localparam logic [2:0]  HDR_LAST     = 3'(HDR_BYTES - 1);

  fsm_state_e        state_r;
  logic [2:0]        hdr_cnt_r;
  logic [39:0]       hdr_sr_r;
  logic [31:0]       addr_shadow_r;
  logic [15:0]       num_shadow_r;
  logic [BUF_AW:0]   wr_ptr_r;
  logic [BUF_AW:0]   rd_ptr_r;

  logic [15:0]       num_in_s;
  logic [BUF_AW:0]   wr_ptr_inc_s;
  logic [BUF_AW:0]   rd_ptr_nxt_s;
  logic              rd_en_s;
  logic              ram_we_s;

  // The sixth header byte completes num; the first five sit in the shift register.
  assign num_in_s     = {hdr_sr_r[7:0], rx_data};
  assign wr_ptr_inc_s = wr_ptr_r + {{BUF_AW{1'b0}}, 1'b1};
  assign ram_we_s     = (state_r == ST_LOAD) && rx_valid;

  // Read pointer look-ahead: the RAM is addressed with the next pointer so the
  // requested byte lands on write_data one cycle after START or data_req.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    rd_en_s      = 1'b0;
    case (state_r)
      ST_START: begin
        rd_ptr_nxt_s = '0;
        rd_en_s      = 1'b1;
      end
      ST_STREAM: begin
        if (data_req && !write_finish && ((16'(rd_ptr_r) + 16'd1) != write_num)) begin
          rd_ptr_nxt_s = rd_ptr_r + {{BUF_AW{1'b0}}, 1'b1};
          rd_en_s      = 1'b1;
        end else begin
          rd_ptr_nxt_s = rd_ptr_r;
          rd_en_s      = 1'b0;
        end
      end
      ST_DONE: begin
        rd_ptr_nxt_s = '0;
      end
      default: begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    endcase
  end

  // Main FSM with header capture, write pointer and registered job outputs.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_r          <= ST_IDLE;
      hdr_cnt_r        <= 3'd0;
      hdr_sr_r         <= 40'd0;
      addr_shadow_r    <= 32'd0;
      num_shadow_r     <= 16'd0;
      wr_ptr_r         <= '0;
      rd_ptr_r         <= '0;
      pi_flag          <= 1'b0;
      write_start_addr <= 32'd0;
      write_num        <= 16'd0;
      busy             <= 1'b0;
      err_len          <= 1'b0;
    end else begin
      pi_flag  <= 1'b0;
      err_len  <= 1'b0;
      rd_ptr_r <= rd_ptr_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid) begin
            hdr_sr_r  <= {hdr_sr_r[31:0], rx_data};
            hdr_cnt_r <= 3'd1;
            busy      <= 1'b1;
            state_r   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (rx_valid) begin
            hdr_sr_r  <= {hdr_sr_r[31:0], rx_data};
            hdr_cnt_r <= hdr_cnt_r + 3'd1;
            if (hdr_cnt_r == HDR_LAST) begin
              hdr_cnt_r <= 3'd0;
              if (hdr_num_ok(num_in_s, BUF_DEPTH_16)) begin
                addr_shadow_r <= hdr_sr_r[39:8];
                num_shadow_r  <= num_in_s;
                wr_ptr_r      <= '0;
                state_r       <= ST_LOAD;
              end else begin
                err_len <= 1'b1;
                busy    <= 1'b0;
                state_r <= ST_IDLE;
              end
            end
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            wr_ptr_r <= wr_ptr_inc_s;
            if (16'(wr_ptr_inc_s) == num_shadow_r) begin
              pi_flag          <= 1'b1;
              write_start_addr <= addr_shadow_r;
              write_num        <= num_shadow_r;
              state_r          <= ST_START;
            end
          end
        end
        ST_START: begin
          state_r <= ST_STREAM;
        end
        ST_STREAM: begin
          if (write_finish) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          wr_ptr_r  <= '0;
          hdr_cnt_r <= 3'd0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  flash_byte_ram #(
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_ram (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .wr_en          (ram_we_s),
    .wr_addr        (wr_ptr_r[BUF_AW-1:0]),
    .wr_data        (rx_data),
    .rd_en          (rd_en_s),
    .rd_addr        (rd_ptr_nxt_s[BUF_AW-1:0]),
    .rd_data        (write_data)
  );

endmodule

// File: tb/tb_flash_write_loader.sv
// Scoreboard bench for flash_write_loader: the driver pushes expected job
// headers and payload bytes, a negedge monitor pops and compares them.
module tb_flash_write_loader;

  logic        system_clk;
  logic        system_reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        data_req;
  logic        write_finish;
  logic        pi_flag;
  logic [31:0] write_start_addr;
  logic [15:0] write_num;
  logic [7:0]  write_data;
  logic        busy;
  logic        err_len;

  int checks   = 0;
  int failures = 0;
  int exp_pi   = 0;
  int exp_err  = 0;
  int seen_pi  = 0;
  int seen_err = 0;

  logic [7:0]  data_q [$];
  logic [47:0] job_q  [$];
  logic [7:0]  pay    [4096];
  bit          pend;

  flash_write_loader dut (
    .system_clk       (system_clk),
    .system_reset_n   (system_reset_n),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .data_req         (data_req),
    .write_finish     (write_finish),
    .pi_flag          (pi_flag),
    .write_start_addr (write_start_addr),
    .write_num        (write_num),
    .write_data       (write_data),
    .busy             (busy),
    .err_len          (err_len)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Reference behaviour: a valid job shows byte 0 after pi_flag, the k-th
  // data_req shows byte min(k, num-1); invalid lengths only raise err_len.
  task automatic run_job(input logic [31:0] addr, input logic [15:0] num, input int nreq,
                         input bit noise, input bit both_last);
    logic [47:0] hdr;
    bit ok;
    int idx;
    hdr = {addr, num};
    ok  = (num != 16'd0) && (num <= 16'd4096);
    if (ok) begin
      job_q.push_back(hdr);
      data_q.push_back(pay[0]);
      exp_pi++;
    end else begin
      exp_err++;
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) tick();
      send_byte(hdr[47-8*i -: 8]);
    end
    if (!ok) begin
      check("busy_after_err", 32'(busy), 32'd0);
      tick();
      check("busy_after_err2", 32'(busy), 32'd0);
      return;
    end
    for (int i = 0; i < 32'(num); i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) tick();
      send_byte(pay[i]);
    end
    check("pi_timing", 32'(pi_flag), 32'd1);
    tick();
    for (int k = 1; k <= nreq; k++) begin
      idx = (k < 32'(num)) ? k : 32'(num) - 1;
      data_req = 1'b1;
      if (both_last && k == nreq) begin
        write_finish = 1'b1;
      end else begin
        data_q.push_back(pay[idx]);
      end
      if (noise) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
      end
      tick();
      data_req     = 1'b0;
      write_finish = 1'b0;
      rx_valid     = 1'b0;
      if (k < nreq && $urandom_range(0, 2) == 0) tick();
    end
    if (!(both_last && nreq > 0)) begin
      write_finish = 1'b1;
      tick();
      write_finish = 1'b0;
    end
    check("busy_in_done", 32'(busy), 32'd1);
    tick();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Monitor: compares pi_flag job fields and every write_data byte the
  // driver has scheduled, one cycle after pi_flag or an accepted data_req.
  always @(negedge system_clk) begin
    if (!system_reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (data_q.size() == 0) begin
          check("write_data_unexpected", 32'd1, 32'd0);
        end else begin
          check("write_data", 32'(write_data), 32'(data_q.pop_front()));
        end
      end
      pend = pi_flag || (data_req && !write_finish);
      if (pi_flag) begin
        seen_pi++;
        if (job_q.size() == 0) begin
          check("pi_unexpected", 32'd1, 32'd0);
        end else begin
          logic [47:0] j;
          j = job_q.pop_front();
          check("write_start_addr", write_start_addr, j[47:16]);
          check("write_num", 32'(write_num), 32'(j[15:0]));
        end
      end
      if (err_len) seen_err++;
    end
  end

  initial begin
    rx_data        = 8'h00;
    rx_valid       = 1'b0;
    data_req       = 1'b0;
    write_finish   = 1'b0;
    system_reset_n = 1'b1;
    #2 system_reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pi", 32'(pi_flag), 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    check("rst_data", 32'(write_data), 32'd0);
    check("rst_addr", write_start_addr, 32'd0);
    check("rst_num", 32'(write_num), 32'd0);
    system_reset_n = 1'b1;
    tick();

    // Directed frame A1 B2 C3 D4 at 0x00010000
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
    run_job(32'h0001_0000, 16'd4, 4, 1'b0, 1'b0);

    // Rejected lengths
    run_job(32'h1234_5678, 16'd0, 0, 1'b0, 1'b0);
    run_job(32'h0000_0100, 16'd4097, 0, 1'b0, 1'b0);

    // Full sector, one extra request beyond the last byte
    for (int i = 0; i < 4096; i++) pay[i] = 8'(i % 256);
    run_job(32'h00AB_0000, 16'd4096, 4097, 1'b0, 1'b0);

    // Host bytes during STREAM are dropped; the next header is accepted
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    run_job(32'hCAFE_0000, 16'd8, 10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    run_job(32'h0000_3000, 16'd3, 3, 1'b0, 1'b0);

    // Reset in the middle of LOAD
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    system_reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pi", 32'(pi_flag), 32'd0);
    check("abort_data", 32'(write_data), 32'd0);
    check("abort_addr", write_start_addr, 32'd0);
    check("abort_num", 32'(write_num), 32'd0);
    check("abort_err", 32'(err_len), 32'd0);
    tick();
    tick();
    system_reset_n = 1'b1;
    tick();
    pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h0F; pay[3] = 8'hF0;
    run_job(32'h0002_0000, 16'd4, 5, 1'b0, 1'b0);

    // data_req and write_finish in the same cycle
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    run_job(32'h0004_4000, 16'd5, 3, 1'b0, 1'b1);

    // Randomized jobs, including occasional rejected lengths
    for (int n = 0; n < 12; n++) begin
      int r;
      logic [15:0] num;
      r = $urandom_range(0, 9);
      if (r == 0) num = 16'd0;
      else if (r == 1) num = 16'($urandom_range(4097, 65535));
      else num = 16'($urandom_range(1, 48));
      for (int i = 0; i < 48; i++) pay[i] = 8'($urandom);
      run_job($urandom, num, $urandom_range(0, 32'(num) + 2),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    check("pi_count", 32'(seen_pi), 32'(exp_pi));
    check("err_count", 32'(seen_err), 32'(exp_err));
    check("data_q_empty", 32'(data_q.size()), 32'd0);
    check("job_q_empty", 32'(job_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
